// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: per-channel synchroniser, optional inversion, stable-time FSM, edge pulses.
// Latency SYNC_STAGES+1+STABLE_TICKS edges with tick_i=1; no backpressure, outputs are registered or state-decoded.
module multi_debouncer #(
  parameter int                  CHANNELS     = 4,
  parameter int                  STABLE_TICKS = 4,
  parameter int                  SYNC_STAGES  = 2,
  parameter logic [CHANNELS-1:0] INVERT       = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_i,
  input  logic                tick_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                busy_o
);

  localparam int            CW   = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  // Encoding chosen so bit 1 is the debounced level and bit 0 marks qualification.
  typedef enum logic [1:0] {
    ST_LOW     = 2'b00,
    ST_DELAY_1 = 2'b01,
    ST_HIGH    = 2'b10,
    ST_DELAY_2 = 2'b11
  } state_t;

  logic [CHANNELS-1:0] w_busy;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   w_x;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sync <= {SYNC_STAGES{INVERT[c]}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i[c]};
      end
    end

    assign w_x = r_sync[SYNC_STAGES-1] ^ INVERT[c];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= ST_LOW;
        r_cnt   <= '0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    // An abort on x wins over a coincident tick, so that tick is never counted.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
        ST_LOW: begin
          if (w_x) begin
            w_state_nxt = ST_DELAY_1;
            w_cnt_nxt   = '0;
          end
        end
        ST_DELAY_1: begin
          if (!w_x) begin
            w_state_nxt = ST_LOW;
          end else if (tick_i) begin
            if (r_cnt == LAST) begin
              w_state_nxt = ST_HIGH;
              w_rise_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (!w_x) begin
            w_state_nxt = ST_DELAY_2;
            w_cnt_nxt   = '0;
          end
        end
        ST_DELAY_2: begin
          if (w_x) begin
            w_state_nxt = ST_HIGH;
          end else if (tick_i) begin
            if (r_cnt == LAST) begin
              w_state_nxt = ST_LOW;
              w_fall_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign level_o[c] = r_state[1];
    assign w_busy[c]  = r_state[0];
    assign rise_o[c]  = r_rise;
    assign fall_o[c]  = r_fall;
  end

  assign busy_o = |w_busy;

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised, multi-channel successor to the single-input push-button debouncer. Each of `CHANNELS` asynchronous inputs is synchronised, optionally polarity-inverted, and filtered by an independent four-state FSM with a programmable stable-time counter. A shared `tick_i` prescaler strobe scales the stable time. Per channel the block produces a clean level plus one-cycle rise and fall pulses for the sequential-multiplier control path.

## Interface
- `CHANNELS`, 4: number of independent inputs (≥1).
- `STABLE_TICKS`, 4: consecutive qualifying ticks needed to accept a new level (≥1).
- `SYNC_STAGES`, 2: synchroniser flop depth (≥2).
- `INVERT`, '0 (`CHANNELS` bits): bit c=1 means input c is active-low.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `btn_i` in `CHANNELS`: raw asynchronous inputs.
- `tick_i` in 1: counting strobe; tie to 1 to count every clock.
- `level_o` out `CHANNELS`: debounced level, active-high after inversion.
- `rise_o` out `CHANNELS`: one-cycle pulse on accepted 0→1.
- `fall_o` out `CHANNELS`: one-cycle pulse on accepted 1→0.
- `busy_o` out 1: OR over channels of state ∈ {DELAY_1, DELAY_2}.

## Operation
- Synchroniser: `SYNC_STAGES` flops per channel. Reset value of each flop is `INVERT[c]`. Filtered input x[c] = last stage XOR `INVERT[c]`, so x[c]=0 out of reset.
- Per-channel FSM, 2-bit encoding LOW=00, DELAY_1=01, HIGH=10, DELAY_2=11. Counter cnt[c] width $clog2(STABLE_TICKS+1).
  - LOW: x=1 → DELAY_1, cnt←0; else stay.
  - DELAY_1: x=0 → LOW (abort, no pulse). Else if tick_i: if cnt==STABLE_TICKS-1 → HIGH and rise; else cnt←cnt+1. Else hold.
  - HIGH: x=0 → DELAY_2, cnt←0; else stay.
  - DELAY_2: x=1 → HIGH (abort, no pulse). Else if tick_i: if cnt==STABLE_TICKS-1 → LOW and fall; else cnt←cnt+1. Else hold.
- Abort takes priority over tick_i in the same cycle; the tick is not counted.
- `tick_i` is ignored in LOW and HIGH.
- `level_o[c]` = state ∈ {HIGH, DELAY_2}, decoded directly from the state register.
- `rise_o` / `fall_o` are registered, high for exactly the one cycle in which `level_o` first shows the new value. They never overlap for one channel.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- Reset (`rst_n`=0 at an edge) sets all FSMs to LOW, cnt to 0, and sync flops to `INVERT`. Any in-progress qualification is discarded.
- Reset values: `level_o`=0, `rise_o`=0, `fall_o`=0, `busy_o`=0.

## Timing
- With `tick_i`=1, a `btn_i` change that stays stable is reflected on `level_o` and the pulse after SYNC_STAGES+1+STABLE_TICKS rising edges. With defaults this is 7 edges.
- With gated `tick_i`, the FSM must observe STABLE_TICKS tick cycles while in DELAY_x. The first tick is counted on the edge after entry to DELAY_x.
- Glitch rejection: a deviation of x shorter than 1+STABLE_TICKS (tick-qualified) cycles never changes `level_o`.
- Counter never wraps. It saturates implicitly because the transition fires at STABLE_TICKS-1.
- STABLE_TICKS=1: DELAY_x lasts exactly one tick cycle.
- Outputs are glitch-free registered or state-decoded signals. Input-to-output paths contain no combinational logic.

## Test plan
Defaults apply unless stated: CHANNELS=4, STABLE_TICKS=4, SYNC_STAGES=2, INVERT=0, tick_i=1.

- Clean press: `btn_i[0]` 0→1 and hold → `level_o[0]`=1 at edge 7, `rise_o[0]`=1 for that one cycle, channels 1-3 stay 0, `busy_o`=1 during edges 3-6.
- Bounce: `btn_i[2]` high for 3 cycles then low → `level_o[2]` stays 0, no `rise_o`/`fall_o`, FSM returns to LOW.
- Release: after ch0 is HIGH, drop `btn_i[0]` → `level_o[0]`=0 7 edges later with a one-cycle `fall_o[0]`. A 2-cycle low glitch during HIGH produces no change.
- Tick gating: `tick_i` pulsed once every 10 cycles, `btn_i[1]` held high → `level_o[1]` rises only after 4 ticks seen in DELAY_1. A tick coinciding with an abort is not counted.
- Inversion: INVERT=4'b0010, `btn_i[1]`=1 through reset → `level_o[1]`=0 with no pulse. Drive `btn_i[1]`=0 → `rise_o[1]` at edge 7.
- Reset mid-qualification: assert `rst_n`=0 for one edge while ch3 is in DELAY_1 with cnt=2 → all outputs 0 on the next cycle. After release, a held input needs the full 7 edges again.
